// File: rtl/pri_arb_pkg.sv
// Shared types and sizes for the 4-way priority / round-robin arbiter.
// Imported by rr_pick and pri_rr_arbiter.
package pri_arb_pkg;

    localparam int N      = 4;
    localparam int IDW    = 2;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic logic [N-1:0] id2onehot(
        input logic [IDW-1:0] id,
        input logic           vld
    );
        logic [N-1:0] oh;
        oh     = '0;
        oh[id] = vld;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select: rotate by ptr, priority-encode, un-rotate.
// Fixed mode forces rotation 0 and picks the highest set bit.
module rr_pick
    import pri_arb_pkg::*;
(
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           mode,
    output logic [IDW-1:0] id,
    output logic           valid
);

    logic [IDW-1:0] amt;
    logic [IDW-1:0] sel;
    logic [N-1:0]   rot;

    assign amt = mode ? '0 : ptr;

    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[IDW'(i) + amt];
        end
    end

    // Later loop hits overwrite earlier ones: ascending gives highest, descending lowest.
    always_comb begin
        sel = '0;
        if (mode) begin
            for (int i = 0; i < N; i++) begin
                if (rot[i]) sel = IDW'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (rot[i]) sel = IDW'(i);
            end
        end
    end

    assign id    = sel + amt;
    assign valid = |req;

endmodule

// File: rtl/pri_rr_arbiter.sv
// Single-resource arbiter with fixed/round-robin policy and hold timeout.
// Grant, owner id and preempt pulse are all registered.
module pri_rr_arbiter
    import pri_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           mode,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           preempt
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_n;
    logic [IDW-1:0]    ptr, ptr_n;
    logic [HOLD_W-1:0] hold_cnt, cnt_n;
    logic [IDW-1:0]    id_n;
    logic              vld_n;
    logic              pre_n;
    logic [IDW-1:0]    pick_id;
    logic              pick_valid;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .mode  (mode),
        .id    (pick_id),
        .valid (pick_valid)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = hold_cnt;
        id_n    = gnt_id;
        vld_n   = gnt_valid;
        pre_n   = 1'b0;
        unique case (state)
            IDLE: begin
                id_n  = '0;
                vld_n = 1'b0;
                if (pick_valid) begin
                    state_n = GRANT;
                    id_n    = pick_id;
                    vld_n   = 1'b1;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (req[gnt_id] && hold_cnt < HOLD_LAST) begin
                    cnt_n = hold_cnt + 1'b1;
                end else begin
                    // Either voluntary drop or timeout; both advance the pointer.
                    state_n = IDLE;
                    ptr_n   = gnt_id + 1'b1;
                    id_n    = '0;
                    vld_n   = 1'b0;
                    pre_n   = req[gnt_id];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= cnt_n;
            gnt       <= id2onehot(id_n, vld_n);
            gnt_id    <= id_n;
            gnt_valid <= vld_n;
            preempt   <= pre_n;
        end
    end

endmodule

// File: tb/tb_pri_rr_arbiter.sv
// Scoreboard bench: two arbiters (MAX_HOLD 8 and 4) share stimulus;
// a reference model pushes expectations, a monitor pops and compares.
module tb_pri_rr_arbiter;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       mode;
    logic [3:0] req;

    logic [3:0] gnt8, gnt4;
    logic [1:0] id8, id4;
    logic       v8, v4, p8, p4;

    always #5 Clock = ~Clock;

    pri_rr_arbiter #(.MAX_HOLD(8)) u8 (
        .Clock(Clock), .Reset(Reset), .mode(mode), .req(req),
        .gnt(gnt8), .gnt_id(id8), .gnt_valid(v8), .preempt(p8)
    );

    pri_rr_arbiter #(.MAX_HOLD(4)) u4 (
        .Clock(Clock), .Reset(Reset), .mode(mode), .req(req),
        .gnt(gnt4), .gnt_id(id4), .gnt_valid(v4), .preempt(p4)
    );

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       v;
        logic       p;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    int total = 0;
    int bad   = 0;

    // Reference model: owner index (-1 = none), granted cycles used, pointer.
    int own[2];
    int used[2];
    int rrp[2];
    bit pre[2];
    int hmax[2] = '{8, 4};

    function automatic int winner(bit m, logic [3:0] r, int p);
        if (m) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic exp_t step(int k, bit r, bit m, logic [3:0] rq);
        exp_t e;
        if (r) begin
            own[k] = -1; used[k] = 0; rrp[k] = 0; pre[k] = 0;
        end else if (own[k] < 0) begin
            pre[k] = 0;
            own[k] = winner(m, rq, rrp[k]);
            used[k] = 1;
        end else if (rq[own[k]] && used[k] < hmax[k]) begin
            used[k]++;
            pre[k] = 0;
        end else begin
            pre[k] = rq[own[k]];
            rrp[k] = (own[k] + 1) % 4;
            own[k] = -1;
        end
        e.g  = (own[k] >= 0) ? 4'(1 << own[k]) : 4'd0;
        e.id = (own[k] >= 0) ? 2'(own[k]) : 2'd0;
        e.v  = (own[k] >= 0);
        e.p  = pre[k];
        return e;
    endfunction

    task automatic cyc(input bit r, input bit m, input logic [3:0] rq);
        @(negedge Clock);
        Reset = r;
        mode  = m;
        req   = rq;
        q8.push_back(step(0, r, m, rq));
        q4.push_back(step(1, r, m, rq));
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("h8 gnt", gnt8, e.g);
                chk("h8 gnt_id", {2'b0, id8}, {2'b0, e.id});
                chk("h8 gnt_valid", {3'b0, v8}, {3'b0, e.v});
                chk("h8 preempt", {3'b0, p8}, {3'b0, e.p});
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("h4 gnt", gnt4, e.g);
                chk("h4 gnt_id", {2'b0, id4}, {2'b0, e.id});
                chk("h4 gnt_valid", {3'b0, v4}, {3'b0, e.v});
                chk("h4 preempt", {3'b0, p4}, {3'b0, e.p});
            end
        end
    end

    initial begin : stim
        logic [3:0] rq;
        bit         m;
        int         guard;
        Reset = 1'b1;
        mode  = 1'b1;
        req   = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            own[k] = -1; used[k] = 0; rrp[k] = 0; pre[k] = 0;
        end
        cyc(1, 1, 4'b1111);
        cyc(1, 1, 4'b1111);
        cyc(0, 1, 4'b1111);
        repeat (2) cyc(0, 1, 4'b0000);
        cyc(1, 0, 4'b0000);
        cyc(0, 0, 4'b1111);
        repeat (2) cyc(0, 0, 4'b0000);
        // fixed priority then drop of the owner
        repeat (3) cyc(0, 1, 4'b0110);
        repeat (3) cyc(0, 1, 4'b0010);
        repeat (2) cyc(0, 1, 4'b0000);
        // round-robin fairness with 3-cycle tenures
        cyc(1, 0, 4'b0000);
        for (int g = 0; g < 5; g++) begin
            guard = 0;
            do begin
                cyc(0, 0, 4'b1111);
                guard++;
            end while (own[0] < 0 && guard < 10);
            repeat (2) cyc(0, 0, 4'b1111);
            rq = 4'b1111;
            if (own[0] >= 0) rq[own[0]] = 1'b0;
            cyc(0, 0, rq);
        end
        repeat (2) cyc(0, 0, 4'b0000);
        // timeouts
        repeat (12) cyc(0, 0, 4'b0001);
        repeat (2) cyc(0, 0, 4'b0000);
        repeat (12) cyc(0, 0, 4'b0011);
        repeat (2) cyc(0, 0, 4'b0000);
        // reset in the 2nd grant cycle
        repeat (3) cyc(0, 0, 4'b1111);
        cyc(1, 0, 4'b1111);
        repeat (3) cyc(0, 0, 4'b1010);
        // mode switch while owner 1 holds, then fixed arbitration
        cyc(1, 0, 4'b0000);
        repeat (2) cyc(0, 0, 4'b1010);
        repeat (2) cyc(0, 1, 4'b1010);
        cyc(0, 1, 4'b1000);
        repeat (3) cyc(0, 1, 4'b1010);
        repeat (2) cyc(0, 1, 4'b0000);
        // random phase
        m  = 1'b0;
        rq = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            end
            if ($urandom_range(0, 15) == 0) m = ~m;
            cyc($urandom_range(0, 63) == 0, m, rq);
        end
        cyc(0, 0, 4'b0000);
        @(posedge Clock);
        #2;
        total++;
        if (q8.size() != 0 || q4.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d left want 0", q8.size(), q4.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pri_rr_arbiter.md
Name: pri_rr_arbiter

Overview:
- Arbitrates a single shared resource between 4 requesters.
- Registered one-hot grant plus encoded owner id. Encoding is the same as the team's 4-bit priority encoder (q = index, v = valid).
- Two selectable policies:
  - fixed priority: highest index wins, same ordering as the priority encoder;
  - round-robin: rotating pointer.
- Grant is held until the owner drops its request or a hold timeout expires.

Parameters:
- N, 4, number of requesters; fixed at 4 in this revision.
- IDW, 2, width of owner id (log2 N).
- MAX_HOLD, 8, max consecutive GRANT cycles before forced release; legal range 1..255.

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high.
- mode  input  1  0 = round-robin, 1 = fixed priority (req[3] highest). Sampled only in IDLE.
- req  input  4  request vector; level-sensitive; held high while the resource is needed.
- gnt  output  4  one-hot grant, registered; 0 when no owner.
- gnt_id  output  2  index of owner; 0 when gnt_valid=0.
- gnt_valid  output  1  1 while any grant is asserted (equals |gnt).
- preempt  output  1  one-cycle pulse in the cycle after a timeout-forced release.

Behaviour:
- Reset: state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0. Reset asserted mid-grant drops gnt on the next edge; no preempt pulse.
- States: IDLE and GRANT only.
- IDLE, req==0: stay in IDLE, outputs 0.
- IDLE, req!=0: select winner, load gnt/gnt_id, hold_cnt=0, go to GRANT. Latency is 1 cycle: req high at edge k gives gnt at edge k+1.
- Winner selection, fixed mode: highest set bit of req.
- Winner selection, round-robin mode: first set bit searching ptr, ptr+1, ... mod 4.
- GRANT, hold: req[owner]=1 and hold_cnt < MAX_HOLD-1 → keep grant, hold_cnt++.
- GRANT, voluntary release: req[owner]=0 → gnt=0, go to IDLE, ptr=(owner+1) mod 4, preempt=0.
- GRANT, forced release: req[owner]=1 and hold_cnt == MAX_HOLD-1 → gnt=0, go to IDLE, ptr=(owner+1) mod 4, preempt=1 for one cycle.
- Dead cycle: exactly one cycle with gnt=0 between any two grants, including re-granting the same requester. The next grant appears one cycle after entering IDLE.
- ptr updates only on release, in both modes. Fixed mode ignores ptr.
- Requests from non-owners during GRANT are ignored; nothing is latched; req is re-sampled in IDLE.
- Mode change during GRANT has no effect until the next IDLE arbitration.
- MAX_HOLD=1: owner gets exactly one GRANT cycle per arbitration. preempt fires if its req is still high.
- hold_cnt width is 8 bits, no wrap possible.
- Invariants:
  - gnt is 0 or one-hot;
  - gnt_id == encode(gnt);
  - gnt_valid == |gnt;
  - gnt[i]=1 only if req[i] was 1 at the arbitration edge.

Decomposition:
- Shared package pri_arb_pkg holds:
  - state enum (IDLE, GRANT);
  - N, IDW;
  - localparam HOLD_W=8.
- One sub-module, rr_pick: combinational rotate → priority-encode → un-rotate.
  - Inputs: req[3:0], ptr[1:0], mode.
  - Outputs: id[1:0], valid.
  - Fixed mode: force rotate amount to 0 and pick the highest bit.
- Top holds the FSM, ptr, hold_cnt and output registers.

Test Plan:
- Reset: Reset=1 for 2 cycles with req=4'b1111 → gnt=0, gnt_id=0, gnt_valid=0, preempt=0. After release, the first grant is gnt=4'b1000 in fixed mode, or gnt=4'b0001 in RR mode (ptr=0).
- Fixed priority: mode=1, req=4'b0110 held → gnt=4'b0100, gnt_id=2 one cycle later.
  - Drop req[2] → 1 dead cycle, then gnt=4'b0010, gnt_id=1.
- Round-robin fairness: mode=0, req=4'b1111 constant, MAX_HOLD=8.
  - Each owner drops and re-raises req after 3 GRANT cycles.
  - Grant order is 0,1,2,3,0 with one dead cycle between grants.
- Timeout: MAX_HOLD=4, mode=0, req=4'b0001 held.
  - gnt=4'b0001 for exactly 4 cycles, then gnt=0 with preempt=1 for 1 cycle, then gnt=4'b0001 again.
  - Repeat with req=4'b0011 → after preempt, gnt=4'b0010.
- Reset mid-grant: Reset asserted in the 2nd GRANT cycle → next edge gnt=0, preempt=0, ptr=0.
  - Deassert with req=4'b1010, mode=0 → gnt=4'b0010.
- Mode switch in GRANT: owner id 1 in RR, set mode=1 mid-grant with req=4'b1010 → grant to 1 unchanged until release. Next grant is 4'b1000 (fixed).
